// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way set-associative data-cache array with true-LRU replacement and registered response.
// Define DCACHE_SRAM_NWAY_FLUSH_EN to build the write-back flush engine and ev_* channel.
module dcache_sram_nway #(
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic                     dirty_i,
    input  logic [$clog2(SETS)-1:0]  set_i,
    input  logic [TAG_W-1:0]         tag_i,
    input  logic [LINE_W-1:0]        data_i,
    output logic                     ready_o,
    output logic                     rvalid_o,
    output logic                     hit_o,
    output logic [$clog2(WAYS)-1:0]  way_o,
    output logic                     valid_o,
    output logic                     dirty_o,
    output logic [TAG_W-1:0]         tag_o,
    output logic [LINE_W-1:0]        data_o,
    input  logic                     flush_i,
    output logic                     flush_busy_o,
    output logic                     flush_done_o,
    output logic                     ev_valid_o,
    input  logic                     ev_ready_i,
    output logic [$clog2(SETS)-1:0]  ev_set_o,
    output logic [TAG_W-1:0]         ev_tag_o,
    output logic [LINE_W-1:0]        ev_data_o
);

    localparam int SW = $clog2(SETS);
    localparam int WW = $clog2(WAYS);

    logic              valid_q [SETS][WAYS];
    logic              dirty_q [SETS][WAYS];
    logic [WW-1:0]     age_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] data_q  [SETS][WAYS];

    logic          accept;
    logic          touch;
    logic          hit;
    logic          found_inv;
    logic [WW-1:0] hit_way;
    logic [WW-1:0] inv_way;
    logic [WW-1:0] lru_way;
    logic [WW-1:0] sel_way;
    logic [WW-1:0] sel_age;

    logic          clr_dirty;
    logic [SW-1:0] scan_set;
    logic [WW-1:0] scan_way;

    // Priority: lowest matching valid way, then lowest invalid way, then the oldest way.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[set_i][w] && (tag_q[set_i][w] == tag_i)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!found_inv && !valid_q[set_i][w]) begin
                found_inv = 1'b1;
                inv_way   = WW'(w);
            end
            if (age_q[set_i][w] == WW'(WAYS-1)) lru_way = WW'(w);
        end
        sel_way = hit ? hit_way : (found_inv ? inv_way : lru_way);
        sel_age = age_q[set_i][sel_way];
    end

    assign accept = req_i & ready_o;
    assign touch  = accept & (we_i | hit);

    // NOTE: only valid, dirty and age are reset; tag/data are qualified by valid and stay reset-free so they can map to SRAM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WW'(w);
                end
            end
        end else begin
            if (accept && we_i) begin
                valid_q[set_i][sel_way] <= 1'b1;
                dirty_q[set_i][sel_way] <= dirty_i;
            end
            if (touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WW'(w) == sel_way)
                        age_q[set_i][w] <= '0;
                    else if (age_q[set_i][w] < sel_age)
                        age_q[set_i][w] <= age_q[set_i][w] + WW'(1);
                end
            end
            if (clr_dirty) dirty_q[scan_set][scan_way] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && we_i) begin
            tag_q[set_i][sel_way]  <= tag_i;
            data_q[set_i][sel_way] <= data_i;
        end
    end

    // Response carries the selected way's contents as they were before this request's write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            hit_o    <= 1'b0;
            way_o    <= '0;
            valid_o  <= 1'b0;
            dirty_o  <= 1'b0;
            tag_o    <= '0;
            data_o   <= '0;
        end else begin
            rvalid_o <= accept;
            if (accept) begin
                hit_o   <= hit;
                way_o   <= sel_way;
                valid_o <= valid_q[set_i][sel_way];
                dirty_o <= dirty_q[set_i][sel_way];
                tag_o   <= tag_q[set_i][sel_way];
                data_o  <= data_q[set_i][sel_way];
            end
        end
    end

`ifdef DCACHE_SRAM_NWAY_FLUSH_EN
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t state_q;
    state_t state_d;
    logic   advance;
    logic   last_line;
    logic   line_dirty;

    assign last_line  = (scan_set == SW'(SETS-1)) && (scan_way == WW'(WAYS-1));
    assign line_dirty = valid_q[scan_set][scan_way] & dirty_q[scan_set][scan_way];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        advance      = 1'b0;
        clr_dirty    = 1'b0;
        ev_valid_o   = 1'b0;
        flush_done_o = 1'b0;
        flush_busy_o = (state_q != IDLE);
        case (state_q)
            IDLE: if (flush_i) state_d = SCAN;
            SCAN: begin
                if (line_dirty) begin
                    state_d = EMIT;
                end else begin
                    advance = 1'b1;
                    if (last_line) state_d = DONE;
                end
            end
            EMIT: begin
                ev_valid_o = 1'b1;
                if (ev_ready_i) begin
                    clr_dirty = 1'b1;
                    advance   = 1'b1;
                    state_d   = last_line ? DONE : SCAN;
                end
            end
            DONE: begin
                flush_done_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan order: ways of a set first, then the next set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scan_set <= '0;
            scan_way <= '0;
        end else if (state_q == IDLE) begin
            scan_set <= '0;
            scan_way <= '0;
        end else if (advance) begin
            if (scan_way == WW'(WAYS-1)) begin
                scan_way <= '0;
                scan_set <= scan_set + SW'(1);
            end else begin
                scan_way <= scan_way + WW'(1);
            end
        end
    end

    assign ready_o   = (state_q == IDLE) & ~flush_i;
    assign ev_set_o  = ev_valid_o ? scan_set : '0;
    assign ev_tag_o  = ev_valid_o ? tag_q[scan_set][scan_way] : '0;
    assign ev_data_o = ev_valid_o ? data_q[scan_set][scan_way] : '0;
`else
    logic unused_flush;

    assign unused_flush = flush_i ^ ev_ready_i;
    assign ready_o      = 1'b1;
    assign clr_dirty    = 1'b0;
    assign scan_set     = '0;
    assign scan_way     = '0;
    assign flush_busy_o = 1'b0;
    assign flush_done_o = 1'b0;
    assign ev_valid_o   = 1'b0;
    assign ev_set_o     = '0;
    assign ev_tag_o     = '0;
    assign ev_data_o    = '0;
`endif

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed self-checking bench for dcache_sram_nway (4 ways, 16 sets); flush cases build when DCACHE_SRAM_NWAY_FLUSH_EN is defined.
module tb_dcache_sram_nway;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_i;
    logic         we_i;
    logic         dirty_i;
    logic [3:0]   set_i;
    logic [22:0]  tag_i;
    logic [255:0] data_i;
    logic         ready_o;
    logic         rvalid_o;
    logic         hit_o;
    logic [1:0]   way_o;
    logic         valid_o;
    logic         dirty_o;
    logic [22:0]  tag_o;
    logic [255:0] data_o;
    logic         flush_i;
    logic         flush_busy_o;
    logic         flush_done_o;
    logic         ev_valid_o;
    logic         ev_ready_i;
    logic [3:0]   ev_set_o;
    logic [22:0]  ev_tag_o;
    logic [255:0] ev_data_o;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int ready_in_flush = 0;

    dcache_sram_nway #(.WAYS(4), .SETS(16), .TAG_W(23), .LINE_W(256)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .dirty_i(dirty_i),
        .set_i(set_i), .tag_i(tag_i), .data_i(data_i), .ready_o(ready_o),
        .rvalid_o(rvalid_o), .hit_o(hit_o), .way_o(way_o), .valid_o(valid_o),
        .dirty_o(dirty_o), .tag_o(tag_o), .data_o(data_o), .flush_i(flush_i),
        .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o), .ev_valid_o(ev_valid_o),
        .ev_ready_i(ev_ready_i), .ev_set_o(ev_set_o), .ev_tag_o(ev_tag_o), .ev_data_o(ev_data_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (flush_done_o) done_cnt++;
        if (flush_busy_o) begin
            busy_cnt++;
            if (ready_o) ready_in_flush++;
        end
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [255:0] mk(input logic [22:0] t);
        return {8{{9'h0A5, t}}};
    endfunction

    task automatic issue(input logic we, input logic dty, input logic [3:0] s,
                         input logic [22:0] t, input logic [255:0] d);
        req_i = 1'b1; we_i = we; dirty_i = dty; set_i = s; tag_i = t; data_i = d;
        @(posedge clk_i); #1;
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

`ifdef DCACHE_SRAM_NWAY_FLUSH_EN
    task automatic wait_ev(input int max, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (ev_valid_o) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic wait_idle(input int max, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (!flush_busy_o) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
`ifdef DCACHE_SRAM_NWAY_FLUSH_EN
        logic         seen;
        logic [255:0] held;
`endif
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; dirty_i = 1'b0; set_i = '0;
        tag_i = '0; data_i = '0; flush_i = 1'b0; ev_ready_i = 1'b0;
        #12;
        check("rst_rvalid", rvalid_o, 0);
        check("rst_hit", hit_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_busy", flush_busy_o, 0);
        check("rst_evvalid", ev_valid_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Cold lookup: miss, lowest invalid way.
        issue(0, 0, 4'd3, 23'h1A, '0);
        check("cold_rvalid", rvalid_o, 1);
        check("cold_hit", hit_o, 0);
        check("cold_way", way_o, 0);
        check("cold_valid", valid_o, 0);
        @(posedge clk_i); #1;
        check("rvalid_pulse", rvalid_o, 0);

        // Fill set 3 with four clean lines.
        for (int i = 0; i < 4; i++) begin
            issue(1, 0, 4'd3, 23'h10 + 23'(i), mk(23'h10 + 23'(i)));
            check($sformatf("fill%0d_way", i), way_o, i);
            check($sformatf("fill%0d_valid", i), valid_o, 0);
        end
        issue(0, 0, 4'd3, 23'h10, '0);
        check("lk10_hit", hit_o, 1);
        check("lk10_way", way_o, 0);
        check("lk10_data", data_o, mk(23'h10));

        // Write-miss evicts the LRU way (way 1, tag 0x11).
        issue(1, 1, 4'd3, 23'h14, mk(23'h14));
        check("evict_hit", hit_o, 0);
        check("evict_way", way_o, 1);
        check("evict_valid", valid_o, 1);
        check("evict_dirty", dirty_o, 0);
        check("evict_tag", tag_o, 23'h11);
        check("evict_data", data_o, mk(23'h11));
        issue(0, 0, 4'd3, 23'h11, '0);
        check("lk11_hit", hit_o, 0);
        check("lk11_way", way_o, 2);
        check("lk11_tag", tag_o, 23'h12);
        issue(0, 0, 4'd3, 23'h14, '0);
        check("lk14_hit", hit_o, 1);
        check("lk14_way", way_o, 1);
        check("lk14_dirty", dirty_o, 1);

        // Write-hit overwrites in place; response shows the old contents.
        issue(1, 1, 4'd3, 23'h10, mk(23'h55));
        check("wh_hit", hit_o, 1);
        check("wh_way", way_o, 0);
        check("wh_olddata", data_o, mk(23'h10));
        check("wh_olddirty", dirty_o, 0);
        issue(0, 0, 4'd3, 23'h10, '0);
        check("wh_newdata", data_o, mk(23'h55));
        check("wh_newdirty", dirty_o, 1);

        // Back-to-back write then lookup in the same set.
        issue(1, 0, 4'd5, 23'h7, mk(23'h7));
        check("b2b_wr_hit", hit_o, 0);
        issue(0, 0, 4'd5, 23'h7, '0);
        check("b2b_rvalid", rvalid_o, 1);
        check("b2b_hit", hit_o, 1);
        check("b2b_data", data_o, mk(23'h7));

        // Set boundaries are independent.
        issue(1, 0, 4'd15, 23'h7FFFFF, mk(23'h7FFFFF));
        issue(0, 0, 4'd15, 23'h7FFFFF, '0);
        check("s15_hit", hit_o, 1);
        issue(0, 0, 4'd0, 23'h7, '0);
        check("s0_miss", hit_o, 0);

`ifdef DCACHE_SRAM_NWAY_FLUSH_EN
        do_reset();
        issue(1, 0, 4'd0, 23'h100, mk(23'h100));
        issue(1, 0, 4'd0, 23'h101, mk(23'h101));
        issue(1, 1, 4'd0, 23'h102, mk(23'h102));
        issue(1, 0, 4'd9, 23'h200, mk(23'h200));
        issue(1, 1, 4'd9, 23'h201, mk(23'h201));
        busy_cnt = 0; done_cnt = 0; ready_in_flush = 0;
        flush_i = 1'b1;
        #1;
        check("fl_ready_start", ready_o, 0);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("fl_busy", flush_busy_o, 1);
        wait_ev(100, seen);
        check("ev0_seen", seen, 1);
        check("ev0_set", ev_set_o, 0);
        check("ev0_tag", ev_tag_o, 23'h102);
        check("ev0_data", ev_data_o, mk(23'h102));
        held = ev_data_o;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            check($sformatf("ev0_hold%0d", i), ev_valid_o, 1);
            check($sformatf("ev0_stable%0d", i), ev_data_o, held);
        end
        ev_ready_i = 1'b1;
        @(posedge clk_i); #1;
        ev_ready_i = 1'b0;
        wait_ev(100, seen);
        check("ev1_seen", seen, 1);
        check("ev1_set", ev_set_o, 9);
        check("ev1_tag", ev_tag_o, 23'h201);
        ev_ready_i = 1'b1;
        @(posedge clk_i); #1;
        ev_ready_i = 1'b0;
        wait_idle(100, seen);
        check("fl_end", seen, 1);
        @(posedge clk_i); #1;
        check("fl_done_once", done_cnt, 1);
        check("fl_cycles", busy_cnt, 70);
        check("fl_ready_low", ready_in_flush, 0);
        issue(0, 0, 4'd0, 23'h102, '0);
        check("pf0_hit", hit_o, 1);
        check("pf0_dirty", dirty_o, 0);
        issue(0, 0, 4'd9, 23'h201, '0);
        check("pf9_valid", valid_o, 1);
        check("pf9_dirty", dirty_o, 0);

        // Reset in the middle of an EMIT.
        issue(1, 1, 4'd4, 23'h300, mk(23'h300));
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        wait_ev(100, seen);
        check("rst_ev_seen", seen, 1);
        done_cnt = 0;
        rst_i = 1'b1;
        #1;
        check("rstfl_busy", flush_busy_o, 0);
        check("rstfl_evvalid", ev_valid_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk_i); #1;
        end
        check("rstfl_nodone", done_cnt, 0);
        check("rstfl_idle", flush_busy_o, 0);
`else
        // Without the flush engine, flush_i is ignored and requests still go through.
        flush_i = 1'b1;
        #1;
        check("nf_ready", ready_o, 1);
        issue(0, 0, 4'd5, 23'h7, '0);
        check("nf_rvalid", rvalid_o, 1);
        check("nf_busy", flush_busy_o, 0);
        @(posedge clk_i); #1;
        check("nf_done", flush_done_o, 0);
        check("nf_evvalid", ev_valid_o, 0);
        flush_i = 1'b0;
        do_reset();
`endif
        // After reset every line is invalid.
        issue(0, 0, 4'd3, 23'h10, '0);
        check("post_rst_hit3", hit_o, 0);
        check("post_rst_valid3", valid_o, 0);
        issue(0, 0, 4'd5, 23'h7, '0);
        check("post_rst_hit5", hit_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
